uart_mem_cmd_decoder: RTL and testbench

- Host-side command responder for the DRAM test top.
- Receives bytes from the UART receiver, decodes write and read frames, and drives the LUT-RAM write/read ports.
- Returns one response byte per valid frame through the UART transmit handshake.
- Lets a host poke and peek the memory under test directly, instead of relying only on the autonomous checker.

---
 rtl/uart_mem_cmd_pkg.sv | 25 ++
 rtl/uart_cmd_timeout.sv | 40 ++++
 rtl/uart_mem_cmd_decoder.sv | 188 ++++++++++++++++++
 tb/tb_uart_mem_cmd_decoder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mem_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_mem_cmd_pkg
// Shared constants and types for the UART memory command decoder.
//   OP_WRITE / OP_READ : frame opcode bytes ('W' / 'R')
//   RSP_ACK / RSP_NAK  : response bytes for a completed write / unknown opcode
//   state_t            : decoder FSM states
// -----------------------------------------------------------------------------
package uart_mem_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  localparam logic [7:0] RSP_ACK  = 8'h2B;
  localparam logic [7:0] RSP_NAK  = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WRITE,
    READ_WAIT,
    TX_WAIT
  } state_t;

endpackage

// File: rtl/uart_cmd_timeout.sv
// -----------------------------------------------------------------------------
// uart_cmd_timeout
// Inter-byte timeout counter. Counts idle cycles while enabled; the count is
// cleared whenever the block is disabled or restarted, so entering a waiting
// state always starts from zero.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   enable   : high while a frame is waiting for its next byte
//   restart  : high on a received-byte strobe (clears the count)
//   expired  : one-cycle pulse on the TIMEOUT_CYCLES-th idle cycle
// -----------------------------------------------------------------------------
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // cnt holds the number of idle cycles already spent, so the idle cycle that
  // finds cnt == LAST is the TIMEOUT_CYCLES-th one. A strobe in that same
  // cycle wins over the timeout.
  assign expired = enable && !restart && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || !enable || restart) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_mem_cmd_decoder.sv
// -----------------------------------------------------------------------------
// uart_mem_cmd_decoder
// Host-side command responder: decodes 'W' addr data and 'R' addr frames
// arriving from a UART receiver, drives the memory write/read ports and
// returns one response byte per frame through the transmit handshake.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   rx_data/_ready     : received byte and its one-cycle strobe
//   tx_data/_ready     : response byte, held valid until tx_data_accepted
//   tx_data_accepted   : transmitter consumed tx_data
//   mem_write_*        : write port (address, data, one-cycle enable)
//   mem_read_address   : read port address, held until the next read frame
//   mem_read_data      : read data, valid READ_LATENCY cycles after address
//   busy               : state is not IDLE
//   error_count        : saturating count of rejected/aborted/dropped events
// -----------------------------------------------------------------------------
module uart_mem_cmd_decoder
  import uart_mem_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 6,
  parameter int READ_LATENCY   = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_data_ready,
  input  logic                  tx_data_accepted,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy,
  output logic [7:0]            error_count
);

  state_t                state, state_nx;
  logic                  is_write, is_write_nx;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nx;
  logic [2:0]            lat_cnt, lat_nx;
  logic [7:0]            tx_data_nx;
  logic                  tx_ready_nx;
  logic                  we_nx;
  logic [ADDR_WIDTH-1:0] waddr_nx, raddr_nx;
  logic [DATA_WIDTH-1:0] wdata_nx;
  logic                  err_inc;
  logic                  timeout_en, timeout_expired;

  assign busy       = (state != IDLE);
  assign timeout_en = (state == GET_ADDR) || (state == GET_DATA);

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .enable  (timeout_en),
    .restart (rx_data_ready),
    .expired (timeout_expired)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned; that is what keeps this block free of latches.
    state_nx    = state;
    is_write_nx = is_write;
    addr_nx     = addr_q;
    lat_nx      = lat_cnt;
    tx_data_nx  = tx_data;
    tx_ready_nx = tx_data_ready;
    we_nx       = 1'b0;
    waddr_nx    = mem_write_address;
    wdata_nx    = mem_write_data;
    raddr_nx    = mem_read_address;
    err_inc     = 1'b0;

    case (state)
      IDLE: begin
        if (rx_data_ready) begin
          if (rx_data == OP_WRITE || rx_data == OP_READ) begin
            is_write_nx = (rx_data == OP_WRITE);
            state_nx    = GET_ADDR;
          end else begin
            tx_data_nx  = RSP_NAK;
            tx_ready_nx = 1'b1;
            err_inc     = 1'b1;
            state_nx    = TX_WAIT;
          end
        end
      end

      GET_ADDR: begin
        if (rx_data_ready) begin
          addr_nx = rx_data[ADDR_WIDTH-1:0];
          if (is_write) begin
            state_nx = GET_DATA;
          end else begin
            // Address becomes valid next cycle; the counter runs down from
            // READ_LATENCY-1 so capture happens on the READ_LATENCY-th cycle.
            raddr_nx = rx_data[ADDR_WIDTH-1:0];
            lat_nx   = 3'(READ_LATENCY - 1);
            state_nx = READ_WAIT;
          end
        end else if (timeout_expired) begin
          err_inc  = 1'b1;
          state_nx = IDLE;
        end
      end

      GET_DATA: begin
        if (rx_data_ready) begin
          we_nx    = 1'b1;
          waddr_nx = addr_q;
          wdata_nx = rx_data[DATA_WIDTH-1:0];
          state_nx = WRITE;
        end else if (timeout_expired) begin
          err_inc  = 1'b1;
          state_nx = IDLE;
        end
      end

      WRITE: begin
        err_inc     = rx_data_ready;
        tx_data_nx  = RSP_ACK;
        tx_ready_nx = 1'b1;
        state_nx    = TX_WAIT;
      end

      READ_WAIT: begin
        err_inc = rx_data_ready;
        if (lat_cnt == 3'd0) begin
          tx_data_nx  = 8'(mem_read_data);
          tx_ready_nx = 1'b1;
          state_nx    = TX_WAIT;
        end else begin
          lat_nx = lat_cnt - 3'd1;
        end
      end

      TX_WAIT: begin
        err_inc = rx_data_ready;
        if (tx_data_accepted) begin
          tx_ready_nx = 1'b0;
          state_nx    = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state             <= IDLE;
      is_write          <= 1'b0;
      addr_q            <= '0;
      lat_cnt           <= '0;
      tx_data           <= 8'h00;
      tx_data_ready     <= 1'b0;
      mem_write_enable  <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      mem_read_address  <= '0;
      error_count       <= 8'h00;
    end else begin
      state             <= state_nx;
      is_write          <= is_write_nx;
      addr_q            <= addr_nx;
      lat_cnt           <= lat_nx;
      tx_data           <= tx_data_nx;
      tx_data_ready     <= tx_ready_nx;
      mem_write_enable  <= we_nx;
      mem_write_address <= waddr_nx;
      mem_write_data    <= wdata_nx;
      mem_read_address  <= raddr_nx;
      if (err_inc && error_count != 8'hFF) begin
        error_count <= error_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_mem_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_uart_mem_cmd_decoder
// Directed and randomized frames against a frame-level reference model: an
// expected memory image, an expected error tally and the response rules.
// A small memory stub (async array + output register, latency 2) sits on the
// DUT memory ports. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_mem_cmd_decoder;

  localparam int AW  = 5;
  localparam int DW  = 6;
  localparam int LAT = 2;
  localparam int TO  = 16;
  localparam int DEPTH = 1 << AW;

  localparam logic [7:0] B_W   = 8'h57;
  localparam logic [7:0] B_R   = 8'h52;
  localparam logic [7:0] B_ACK = 8'h2B;
  localparam logic [7:0] B_NAK = 8'h3F;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_data_ready;
  logic [7:0]    tx_data;
  logic          tx_data_ready;
  logic          tx_data_accepted;
  logic [AW-1:0] mem_write_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_enable;
  logic [AW-1:0] mem_read_address;
  logic [DW-1:0] mem_read_data;
  logic          busy;
  logic [7:0]    error_count;

  always #5 clk = ~clk;

  uart_mem_cmd_decoder #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .READ_LATENCY  (LAT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_data          (rx_data),
    .rx_data_ready    (rx_data_ready),
    .tx_data          (tx_data),
    .tx_data_ready    (tx_data_ready),
    .tx_data_accepted (tx_data_accepted),
    .mem_write_address(mem_write_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_address (mem_read_address),
    .mem_read_data    (mem_read_data),
    .busy             (busy),
    .error_count      (error_count)
  );

  // Memory stub on the DUT ports.
  logic [DW-1:0] ram [0:DEPTH-1];
  logic [DW-1:0] rd_q;
  int            wr_count = 0;

  always @(posedge clk) begin
    if (mem_write_enable) begin
      ram[mem_write_address] <= mem_write_data;
      wr_count <= wr_count + 1;
    end
    rd_q <= ram[mem_read_address];
  end
  assign mem_read_data = rd_q;

  // Reference model state.
  logic [DW-1:0] exp_mem [0:DEPTH-1];
  int exp_err = 0;
  int exp_wr  = 0;

  int checks = 0;
  int errors = 0;

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the next falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data       = b;
    rx_data_ready = 1'b1;
    @(negedge clk);
    rx_data_ready = 1'b0;
    rx_data       = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expects TX_WAIT on entry: hold for 'hold' cycles (dropping 'drops' bytes),
  // then accept, optionally with a colliding byte in the accept cycle.
  task automatic finish_tx(input logic [7:0] exp_tx, input int hold, input int drops,
                           input bit drop_at_accept);
    check("tx_ready", tx_data_ready, 1);
    check("tx_data", tx_data, exp_tx);
    for (int i = 0; i < hold; i++) begin
      if (i < drops) begin
        send_byte(8'($urandom));
        exp_err = sat_inc(exp_err);
      end else begin
        @(negedge clk);
      end
      check("tx_hold_ready", tx_data_ready, 1);
      check("tx_hold_data", tx_data, exp_tx);
    end
    tx_data_accepted = 1'b1;
    if (drop_at_accept) begin
      rx_data       = 8'($urandom);
      rx_data_ready = 1'b1;
      exp_err       = sat_inc(exp_err);
    end
    @(negedge clk);
    tx_data_accepted = 1'b0;
    rx_data_ready    = 1'b0;
    check("tx_ready_drop", tx_data_ready, 0);
    check("busy_after_tx", busy, 0);
    check("error_count", error_count, exp_err);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int gap,
                          input bit drop_in_write, input int hold, input int drops,
                          input bit drop_acc);
    int am, dm;
    am = a % DEPTH;
    dm = d % (1 << DW);
    send_byte(B_W);
    idle(gap);
    send_byte(a);
    idle(gap);
    send_byte(d);
    check("wr_en", mem_write_enable, 1);
    check("wr_addr", mem_write_address, am);
    check("wr_data", mem_write_data, dm);
    check("wr_tx_early", tx_data_ready, 0);
    exp_mem[am] = DW'(dm);
    exp_wr++;
    if (drop_in_write) begin
      send_byte(8'($urandom));
      exp_err = sat_inc(exp_err);
    end else begin
      @(negedge clk);
    end
    check("wr_en_pulse", mem_write_enable, 0);
    check("wr_count", wr_count, exp_wr);
    finish_tx(B_ACK, hold, drops, drop_acc);
  endtask

  task automatic do_read(input logic [7:0] a, input int gap, input bit drop_wait,
                         input int hold, input int drops, input bit drop_acc);
    int am;
    am = a % DEPTH;
    send_byte(B_R);
    idle(gap);
    send_byte(a);
    check("rd_addr", mem_read_address, am);
    for (int k = 1; k <= LAT; k++) begin
      check("rd_tx_early", tx_data_ready, 0);
      check("rd_busy", busy, 1);
      if (drop_wait && k == 1) begin
        send_byte(8'($urandom));
        exp_err = sat_inc(exp_err);
      end else begin
        @(negedge clk);
      end
    end
    finish_tx(8'(exp_mem[am]), hold, drops, drop_acc);
    check("rd_wr_count", wr_count, exp_wr);
  endtask

  task automatic do_unknown(input logic [7:0] b, input int hold, input int drops,
                            input bit drop_acc);
    send_byte(b);
    exp_err = sat_inc(exp_err);
    finish_tx(B_NAK, hold, drops, drop_acc);
  endtask

  // Open a frame, optionally supply the write address, then go silent.
  task automatic do_timeout(input bit is_w, input bit with_addr);
    send_byte(is_w ? B_W : B_R);
    if (is_w && with_addr) send_byte(8'($urandom));
    idle(TO - 1);
    check("to_busy_before", busy, 1);
    idle(1);
    check("to_busy_after", busy, 0);
    exp_err = sat_inc(exp_err);
    check("to_error_count", error_count, exp_err);
    check("to_no_tx", tx_data_ready, 0);
    check("to_no_write", wr_count, exp_wr);
  endtask

  initial begin
    rst              = 1'b1;
    rx_data          = 8'h00;
    rx_data_ready    = 1'b0;
    tx_data_accepted = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_tx_data", tx_data, 0);
    check("rst_tx_ready", tx_data_ready, 0);
    check("rst_wr_en", mem_write_enable, 0);
    check("rst_wr_addr", mem_write_address, 0);
    check("rst_wr_data", mem_write_data, 0);
    check("rst_rd_addr", mem_read_address, 0);
    check("rst_busy", busy, 0);
    check("rst_err", error_count, 0);

    // Fill the whole memory so every later read has a defined expectation.
    for (int i = 0; i < DEPTH; i++) begin
      do_write(8'(i), 8'($urandom), 0, 1'b0, 0, 0, 1'b0);
    end

    // Write then read back.
    do_write(8'h05, 8'h2A, 0, 1'b0, 0, 0, 1'b0);
    do_read(8'h05, 0, 1'b0, 0, 0, 1'b0);
    check("rd_0x2a", tx_data, 8'h2A);

    // Unknown opcode.
    do_unknown(8'h41, 0, 0, 1'b0);

    // Timeout after address, then a normal read.
    do_timeout(1'b1, 1'b1);
    do_read(8'h03, 0, 1'b0, 0, 0, 1'b0);

    // Longest gap that must not time out.
    do_write(8'h0A, 8'h15, TO - 1, 1'b0, 0, 0, 1'b0);

    // Backpressure with two dropped bytes, then overruns in WRITE/READ_WAIT
    // and in the accept cycle.
    do_read(8'h00, 0, 1'b0, 100, 2, 1'b0);
    do_write(8'h11, 8'h22, 1, 1'b1, 2, 1, 1'b1);
    do_read(8'h11, 1, 1'b1, 1, 0, 1'b1);

    // Reset mid-frame discards the frame; 0x3F is then an opcode.
    send_byte(B_W);
    send_byte(8'h1F);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", error_count, 0);
    check("mid_rst_tx", tx_data, 0);
    check("mid_rst_rd_addr", mem_read_address, 0);
    do_unknown(8'h3F, 0, 0, 1'b0);
    check("mid_rst_no_write", wr_count, exp_wr);

    // Upper bits of address and data are ignored.
    do_write(8'hFF, 8'hFF, 0, 1'b0, 0, 0, 1'b0);
    do_read(8'h1F, 0, 1'b0, 0, 0, 1'b0);
    check("mask_rd", tx_data, 8'h3F);

    // Randomized frame mix.
    for (int n = 0; n < 60; n++) begin
      int kind, gap, hold, drops;
      bit dflag, aflag;
      kind  = int'($urandom_range(0, 9));
      gap   = int'($urandom_range(0, TO - 1));
      hold  = int'($urandom_range(0, 4));
      drops = int'($urandom_range(0, 2));
      dflag = 1'($urandom);
      aflag = 1'($urandom);
      if (kind <= 3) begin
        do_write(8'($urandom), 8'($urandom), gap, dflag, hold, drops, aflag);
      end else if (kind <= 7) begin
        do_read(8'($urandom), gap, dflag, hold, drops, aflag);
      end else if (kind == 8) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (b == B_W || b == B_R) b = 8'h00;
        do_unknown(b, hold, drops, aflag);
      end else begin
        do_timeout(1'($urandom), 1'($urandom));
      end
    end

    // Saturation: flood overruns while a response is pending.
    do_unknown(8'h7E, 300, 300, 1'b0);
    check("err_saturated", error_count, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
